// File: rtl/game_pkg.sv
// Shared types and board-size helpers for the game control blocks.
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CHECK,
    S_SHOW,
    S_DONE
  } reveal_state_t;

  localparam logic [4:0] DIM_L1 = 5'd8;
  localparam logic [4:0] DIM_L2 = 5'd12;
  localparam logic [4:0] DIM_L3 = 5'd16;

  function automatic logic [4:0] level_to_dim(input logic [1:0] level);
    case (level)
      2'd1:    return DIM_L1;
      2'd2:    return DIM_L2;
      2'd3:    return DIM_L3;
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detect for frame-paced blocks: pulse while sig is high and was low last cycle.
module edge_detector (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= sig;
  end

  // Combinational on the live input so an edge landing on the SHOW entry cycle is
  // seen (and ignored) by the FSM in the state where it actually happened.
  assign rise = sig & ~prev;

endmodule

// File: rtl/mine_reveal_ctrl.sv
// End-of-game mine reveal: scans the mine map row-major and shows each mine for a
// fixed number of frames, then writes it back as revealed.
//
// state   | meaning
// S_IDLE  | waiting for an explode request with a game running
// S_READ  | map address for the current cell is on the bus
// S_CHECK | map data valid; branch on mine / no mine
// S_SHOW  | mine overlay active, counting vblank edges; extra cycle carries reveal_we
// S_DONE  | reveal finished, wait for clear
module mine_reveal_ctrl
  import game_pkg::*;
#(
  parameter int FRAMES_PER_MINE = 4,
  parameter int MAX_DIM         = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [1:0]                         level,
  input  logic                               explode_req,
  input  logic                               clear,
  input  logic                               vblnk,
  output logic [$clog2(MAX_DIM+1)-1:0]       map_addr_x,
  output logic [$clog2(MAX_DIM+1)-1:0]       map_addr_y,
  input  logic                               map_is_mine,
  output logic                               reveal_we,
  output logic [$clog2(MAX_DIM+1)-1:0]       mine_ind_x,
  output logic [$clog2(MAX_DIM+1)-1:0]       mine_ind_y,
  output logic                               explode,
  output logic                               busy,
  output logic                               done,
  output logic [7:0]                         mine_cnt
);

  localparam int CW = $clog2(MAX_DIM + 1);

  reveal_state_t state;
  logic [CW-1:0] dim;
  logic [CW-1:0] cell_x;
  logic [CW-1:0] cell_y;
  logic [3:0]    frame_cnt;
  logic          vblnk_rise;
  logic          last_cell;
  logic          advance;

  edge_detector u_vblnk_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (vblnk),
    .rise (vblnk_rise)
  );

  assign map_addr_x = cell_x;
  assign map_addr_y = cell_y;

  always_comb begin
    last_cell = (cell_x == dim) && (cell_y == dim);
    // A cell is finished either on an empty CHECK or on the write-back cycle of SHOW.
    advance   = ((state == S_CHECK) && !map_is_mine) ||
                ((state == S_SHOW) && reveal_we);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      dim        <= '0;
      cell_x     <= '0;
      cell_y     <= '0;
      frame_cnt  <= '0;
      reveal_we  <= 1'b0;
      mine_ind_x <= '0;
      mine_ind_y <= '0;
      explode    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mine_cnt   <= '0;
    end else begin
      reveal_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (explode_req && (level != 2'd0)) begin
            dim      <= CW'(level_to_dim(level));
            cell_x   <= CW'(1);
            cell_y   <= CW'(1);
            mine_cnt <= '0;
            busy     <= 1'b1;
            state    <= S_READ;
          end
        end
        S_READ: state <= S_CHECK;
        S_CHECK: begin
          if (map_is_mine) begin
            mine_ind_x <= cell_x;
            mine_ind_y <= cell_y;
            frame_cnt  <= 4'(FRAMES_PER_MINE);
            explode    <= 1'b1;
            state      <= S_SHOW;
          end
        end
        S_SHOW: begin
          if (!reveal_we && vblnk_rise) begin
            frame_cnt <= frame_cnt - 4'd1;
            if (frame_cnt == 4'd1) begin
              reveal_we <= 1'b1;
              if (mine_cnt != 8'hFF) mine_cnt <= mine_cnt + 8'd1;
            end
          end
        end
        S_DONE: begin
          if (clear) begin
            done  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (advance) begin
        explode <= 1'b0;
        if (last_cell) begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_DONE;
        end else begin
          state <= S_READ;
          if (cell_x == dim) begin
            cell_x <= CW'(1);
            cell_y <= cell_y + CW'(1);
          end else begin
            cell_x <= cell_x + CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mine_reveal_ctrl.sv
// Directed bench for mine_reveal_ctrl with a registered mine-map model and vblank source.
module tb_mine_reveal_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] level = 2'd0;
  logic       explode_req = 1'b0;
  logic       clear = 1'b0;
  logic       vblnk;
  logic [4:0] map_addr_x, map_addr_y;
  logic       map_is_mine = 1'b0;
  logic       reveal_we;
  logic [4:0] mine_ind_x, mine_ind_y;
  logic       explode, busy, done;
  logic [7:0] mine_cnt;

  logic       mine_map [0:31][0:31];
  logic       vb_en = 1'b0;
  logic       vb_man = 1'b0;
  logic [3:0] vb_phase = 4'd0;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  int we_cnt = 0;
  int we_bad = 0;
  logic [9:0] we_log[$];

  always #5 clk = ~clk;

  mine_reveal_ctrl #(.FRAMES_PER_MINE(2), .MAX_DIM(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .level       (level),
    .explode_req (explode_req),
    .clear       (clear),
    .vblnk       (vblnk),
    .map_addr_x  (map_addr_x),
    .map_addr_y  (map_addr_y),
    .map_is_mine (map_is_mine),
    .reveal_we   (reveal_we),
    .mine_ind_x  (mine_ind_x),
    .mine_ind_y  (mine_ind_y),
    .explode     (explode),
    .busy        (busy),
    .done        (done),
    .mine_cnt    (mine_cnt)
  );

  always @(posedge clk) map_is_mine <= mine_map[map_addr_y][map_addr_x];

  always @(negedge clk) vb_phase <= vb_phase + 4'd1;
  assign vblnk = vb_en ? (vb_phase < 4'd2) : vb_man;

  always @(negedge clk) begin
    if (explode) exp_cnt++;
    if (reveal_we) begin
      we_cnt++;
      we_log.push_back({map_addr_x, map_addr_y});
      if (!explode) we_bad++;
    end
  end

  task automatic clear_map();
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++)
        mine_map[y][x] = 1'b0;
  endtask

  task automatic clear_log();
    exp_cnt = 0;
    we_cnt  = 0;
    we_bad  = 0;
    we_log.delete();
  endtask

  task automatic go_idle();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, explode, reveal_we} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, explode, reveal_we});
    end
    checks++;
    if (mine_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_mine_cnt got=%0d exp=0", mine_cnt);
    end
    checks++;
    if ({map_addr_x, map_addr_y, mine_ind_x, mine_ind_y} !== 20'd0) begin
      errors++; $display("FAIL reset_indices got=%h exp=0", {map_addr_x, map_addr_y, mine_ind_x, mine_ind_y});
    end
  endtask

  task automatic test_level0();
    @(negedge clk); level = 2'd0; explode_req = 1'b1;
    @(negedge clk); explode_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL level0_idle busy_done got=%b exp=00", {busy, done});
    end
    checks++;
    if ({map_addr_x, map_addr_y} !== 10'd0) begin
      errors++; $display("FAIL level0_addr got=%h exp=0", {map_addr_x, map_addr_y});
    end
  endtask

  task automatic test_empty_scan();
    clear_map(); clear_log();
    @(negedge clk); level = 2'd1; explode_req = 1'b1;
    for (int i = 1; i <= 129; i++) begin
      @(negedge clk);
      explode_req = 1'b0;
      if (i == 1) begin
        checks++;
        if ({busy, map_addr_x, map_addr_y} !== {1'b1, 5'd1, 5'd1}) begin
          errors++; $display("FAIL empty_start got busy=%b x=%0d y=%0d exp busy=1 x=1 y=1", busy, map_addr_x, map_addr_y);
        end
      end
      if (i == 128) begin
        checks++;
        if (done !== 1'b0) begin
          errors++; $display("FAIL empty_done_early got=%b exp=0", done);
        end
      end
    end
    checks++;
    if ({done, busy} !== 2'b10) begin
      errors++; $display("FAIL empty_done_129 got done_busy=%b exp=10", {done, busy});
    end
    checks++;
    if ({exp_cnt, we_cnt} !== 64'd0 || mine_cnt !== 8'd0) begin
      errors++; $display("FAIL empty_no_mines got explode=%0d we=%0d cnt=%0d exp 0 0 0", exp_cnt, we_cnt, mine_cnt);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL done_holds got=%b exp=1", done);
    end
    go_idle();
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++; $display("FAIL clear_to_idle got done_busy=%b exp=00", {done, busy});
    end
  endtask

  task automatic test_clear_during_scan();
    clear_map(); clear_log();
    @(negedge clk); level = 2'd1; explode_req = 1'b1;
    for (int i = 1; i <= 129; i++) begin
      @(negedge clk);
      explode_req = 1'b0;
      clear = (i == 10);
      if (i == 128) begin
        checks++;
        if (done !== 1'b0) begin
          errors++; $display("FAIL scan_clear_early got=%b exp=0", done);
        end
      end
    end
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL scan_clear_ignored got done=%b exp=1", done);
    end
    go_idle();
  endtask

  task automatic test_single_mine();
    clear_map(); clear_log();
    mine_map[5][3] = 1'b1;
    vb_en = 1'b0; vb_man = 1'b0;
    @(negedge clk); level = 2'd1; explode_req = 1'b1;
    for (int i = 1; i <= 137; i++) begin
      @(negedge clk);
      explode_req = 1'b0;
      if (i == 70) begin
        checks++;
        if (explode !== 1'b0) begin
          errors++; $display("FAIL single_pre_show got explode=%b exp=0", explode);
        end
      end
      if (i == 71) begin
        checks++;
        if ({explode, mine_ind_x, mine_ind_y, map_addr_x, map_addr_y} !== {1'b1, 5'd3, 5'd5, 5'd3, 5'd5}) begin
          errors++; $display("FAIL single_show got explode=%b ind=(%0d,%0d) addr=(%0d,%0d) exp 1 (3,5) (3,5)",
                             explode, mine_ind_x, mine_ind_y, map_addr_x, map_addr_y);
        end
      end
      if (i == 77) begin
        checks++;
        if ({explode, reveal_we} !== 2'b10) begin
          errors++; $display("FAIL single_one_edge got explode_we=%b exp=10", {explode, reveal_we});
        end
      end
      if (i == 78) begin
        checks++;
        if ({reveal_we, explode, map_addr_x, map_addr_y, mine_cnt} !== {1'b1, 1'b1, 5'd3, 5'd5, 8'd1}) begin
          errors++; $display("FAIL single_writeback got we=%b explode=%b addr=(%0d,%0d) cnt=%0d exp 1 1 (3,5) 1",
                             reveal_we, explode, map_addr_x, map_addr_y, mine_cnt);
        end
      end
      if (i == 79) begin
        checks++;
        if ({reveal_we, explode, map_addr_x, map_addr_y} !== {1'b0, 1'b0, 5'd4, 5'd5}) begin
          errors++; $display("FAIL single_after got we=%b explode=%b addr=(%0d,%0d) exp 0 0 (4,5)",
                             reveal_we, explode, map_addr_x, map_addr_y);
        end
      end
      if (i == 136) begin
        checks++;
        if (done !== 1'b0) begin
          errors++; $display("FAIL single_done_early got=%b exp=0", done);
        end
      end
      // first rise lands on the CHECK->SHOW cycle and must not be counted
      case (i)
        70, 73, 77: vb_man = 1'b1;
        72, 74, 78: vb_man = 1'b0;
        default: ;
      endcase
    end
    checks++;
    if ({done, mine_cnt} !== {1'b1, 8'd1}) begin
      errors++; $display("FAIL single_done got done=%b cnt=%0d exp 1 1", done, mine_cnt);
    end
    checks++;
    if (we_cnt !== 1 || we_bad !== 0) begin
      errors++; $display("FAIL single_we_count got we=%0d bad=%0d exp 1 0", we_cnt, we_bad);
    end
    go_idle();
  endtask

  task automatic test_two_mines();
    int last_we;
    int done_at;
    clear_map(); clear_log();
    mine_map[1][1] = 1'b1;
    mine_map[16][16] = 1'b1;
    last_we = -10; done_at = 0;
    vb_en = 1'b1;
    @(negedge clk); level = 2'd3; explode_req = 1'b1;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      explode_req = 1'b0;
      if (reveal_we) last_we = i;
      if (done) begin
        done_at = i;
        break;
      end
      if (i == 50) begin
        explode_req = 1'b1;
        level = 2'd1;
      end
    end
    vb_en = 1'b0;
    checks++;
    if (done_at == 0) begin
      errors++; $display("FAIL two_timeout got done=%b exp done within 3000 cycles", done);
    end
    checks++;
    if (we_cnt !== 2 || we_bad !== 0) begin
      errors++; $display("FAIL two_we_count got we=%0d bad=%0d exp 2 0", we_cnt, we_bad);
    end
    checks++;
    if (we_log[0] !== {5'd1, 5'd1}) begin
      errors++; $display("FAIL two_first got=%h exp=%h", we_log[0], {5'd1, 5'd1});
    end
    checks++;
    if (we_log[1] !== {5'd16, 5'd16}) begin
      errors++; $display("FAIL two_second got=%h exp=%h", we_log[1], {5'd16, 5'd16});
    end
    checks++;
    if (done_at != last_we + 1) begin
      errors++; $display("FAIL two_done_follows got done_at=%0d exp=%0d", done_at, last_we + 1);
    end
    checks++;
    if ({mine_cnt, mine_ind_x, mine_ind_y} !== {8'd2, 5'd16, 5'd16}) begin
      errors++; $display("FAIL two_final got cnt=%0d ind=(%0d,%0d) exp 2 (16,16)", mine_cnt, mine_ind_x, mine_ind_y);
    end
    go_idle();
  endtask

  task automatic test_reset_mid_show();
    clear_map(); clear_log();
    mine_map[1][1] = 1'b1;
    vb_en = 1'b0; vb_man = 1'b0;
    @(negedge clk); level = 2'd1; explode_req = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      explode_req = 1'b0;
      if (i == 3) begin
        checks++;
        if (explode !== 1'b1) begin
          errors++; $display("FAIL rstshow_in_show got explode=%b exp=1", explode);
        end
      end
      if (i == 7) begin
        checks++;
        if ({busy, done, explode, reveal_we, mine_cnt, mine_ind_x, mine_ind_y, map_addr_x, map_addr_y} !== 32'd0) begin
          errors++; $display("FAIL rstshow_outputs got busy=%b done=%b explode=%b we=%b cnt=%0d ind=(%0d,%0d) addr=(%0d,%0d) exp all 0",
                             busy, done, explode, reveal_we, mine_cnt, mine_ind_x, mine_ind_y, map_addr_x, map_addr_y);
        end
        rst = 1'b0;
        vb_man = 1'b0;
      end
      if (i == 4) vb_man = 1'b1;
      if (i == 5) vb_man = 1'b0;
      // terminal vblank edge coincides with the reset cycle
      if (i == 6) begin
        vb_man = 1'b1;
        rst = 1'b1;
      end
    end
    checks++;
    if (we_cnt !== 0 || reveal_we !== 1'b0) begin
      errors++; $display("FAIL rstshow_no_we got we=%0d exp 0", we_cnt);
    end
    @(negedge clk); level = 2'd2; explode_req = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      explode_req = 1'b0;
      if (i == 1) begin
        checks++;
        if ({busy, map_addr_x, map_addr_y} !== {1'b1, 5'd1, 5'd1}) begin
          errors++; $display("FAIL restart_addr got busy=%b addr=(%0d,%0d) exp 1 (1,1)", busy, map_addr_x, map_addr_y);
        end
      end
      if (i == 3) begin
        checks++;
        if ({explode, mine_ind_x, mine_ind_y, mine_cnt} !== {1'b1, 5'd1, 5'd1, 8'd0}) begin
          errors++; $display("FAIL restart_show got explode=%b ind=(%0d,%0d) cnt=%0d exp 1 (1,1) 0",
                             explode, mine_ind_x, mine_ind_y, mine_cnt);
        end
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    clear_map();
    test_reset();
    test_level0();
    test_empty_scan();
    test_clear_during_scan();
    test_single_mine();
    test_two_mines();
    test_reset_mid_show();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
